// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multicycle control unit for an RV32I-subset datapath.
//
// Sequences every instruction through IF -> ID -> EX -> MEM -> WB. MEM lasts
// MEM_LATENCY cycles; every other state lasts one cycle. Control strobes are decoded
// from the instruction and the current state.
//
// Ports:
//   clk         in   1   system clock, rising edge
//   rst         in   1   synchronous, active-high reset
//   instr       in  32   current instruction, stable from IF through WB
//   Zero        in   1   ALU zero flag, sampled only in EX
//   PCSrc       out  1   1 = PC + branch offset, 0 = PC + 4 (WB only)
//   ALUSrc      out  1   1 = immediate operand, 0 = rs2
//   RegWrite    out  1   register file write strobe (WB only)
//   MemToReg    out  1   1 = write back load data, 0 = ALU result (WB only)
//   ALUCtrl     out  4   ALU operation select
//   loadPC      out  1   PC update strobe, one pulse per instruction (WB)
//   MemRead     out  1   data memory read strobe (MEM, loads)
//   MemWrite    out  1   data memory write strobe (MEM, stores)
//   retired_cnt out 32   retired instruction count (only with
//                        MULTICYCLE_CTRL_RETIRE_CNT_EN defined)
//
// Parameter MEM_LATENCY: cycles spent in MEM, legal range 1..15.
// Optional feature macro: MULTICYCLE_CTRL_RETIRE_CNT_EN.

module multicycle_ctrl #(
  parameter int unsigned MEM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        Zero,
  output logic        PCSrc,
  output logic        ALUSrc,
  output logic        RegWrite,
  output logic        MemToReg,
  output logic [3:0]  ALUCtrl,
  output logic        loadPC,
  output logic        MemRead,
  output logic        MemWrite
`ifdef MULTICYCLE_CTRL_RETIRE_CNT_EN
  ,
  output logic [31:0] retired_cnt
`endif
);

  typedef enum logic [2:0] {StIf, StId, StEx, StMem, StWb} state_e;

  localparam logic [3:0] AluAnd = 4'b0000;
  localparam logic [3:0] AluOr  = 4'b0001;
  localparam logic [3:0] AluAdd = 4'b0010;
  localparam logic [3:0] AluXor = 4'b0101;
  localparam logic [3:0] AluSub = 4'b0110;
  localparam logic [3:0] AluSlt = 4'b0111;
  localparam logic [3:0] AluSrl = 4'b1000;
  localparam logic [3:0] AluSll = 4'b1001;
  localparam logic [3:0] AluSra = 4'b1010;

  localparam logic [3:0] LastMemCnt = 4'(MEM_LATENCY - 1);

  state_e     r_state;
  state_e     w_state_next;
  logic [3:0] r_mem_cnt;
  logic       r_br_taken;

  logic [6:0] w_opcode;
  logic [2:0] w_funct3;
  logic       w_alt;  // funct7[5]: SUB/SRA select
  logic       w_is_r, w_is_i, w_is_lw, w_is_sw, w_is_beq;
  logic [3:0] w_alu_ctrl;
  logic       w_alu_src;
  logic       w_unused_instr_bits;

  assign w_opcode = instr[6:0];
  assign w_funct3 = instr[14:12];
  assign w_alt    = instr[30];
  assign w_unused_instr_bits = ^{instr[31], instr[29:15], instr[11:7]};

  assign w_is_r   = (w_opcode == 7'b0110011);
  assign w_is_i   = (w_opcode == 7'b0010011);
  assign w_is_lw  = (w_opcode == 7'b0000011);
  assign w_is_sw  = (w_opcode == 7'b0100011);
  assign w_is_beq = (w_opcode == 7'b1100011);

  assign w_alu_src = w_is_i | w_is_lw | w_is_sw;

  // R- and I-type share the funct3 map; only R-type honours funct7[5] for SUB.
  always_comb begin
    w_alu_ctrl = AluAdd;
    if (w_is_r || w_is_i) begin
      case (w_funct3)
        3'b000:  w_alu_ctrl = (w_is_r && w_alt) ? AluSub : AluAdd;
        3'b001:  w_alu_ctrl = AluSll;
        3'b010:  w_alu_ctrl = AluSlt;
        3'b100:  w_alu_ctrl = AluXor;
        3'b101:  w_alu_ctrl = w_alt ? AluSra : AluSrl;
        3'b110:  w_alu_ctrl = AluOr;
        3'b111:  w_alu_ctrl = AluAnd;
        default: w_alu_ctrl = AluAdd;  // sltu/sltiu unsupported
      endcase
    end else if (w_is_beq) begin
      w_alu_ctrl = AluSub;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= StIf;
      r_mem_cnt  <= 4'd0;
      r_br_taken <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (r_state == StEx) begin
        r_mem_cnt  <= 4'd0;
        r_br_taken <= w_is_beq & Zero;
      end else if (r_state == StMem) begin
        r_mem_cnt <= r_mem_cnt + 4'd1;
      end else if (r_state == StWb) begin
        r_br_taken <= 1'b0;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    PCSrc        = 1'b0;
    ALUSrc       = 1'b0;
    RegWrite     = 1'b0;
    MemToReg     = 1'b0;
    ALUCtrl      = 4'b0000;
    loadPC       = 1'b0;
    MemRead      = 1'b0;
    MemWrite     = 1'b0;
    case (r_state)
      StIf: w_state_next = StId;
      StId: begin
        w_state_next = StEx;
        ALUSrc       = w_alu_src;
        ALUCtrl      = w_alu_ctrl;
      end
      StEx: begin
        w_state_next = StMem;
        ALUSrc       = w_alu_src;
        ALUCtrl      = w_alu_ctrl;
      end
      StMem: begin
        if (r_mem_cnt == LastMemCnt) w_state_next = StWb;
        ALUSrc   = w_alu_src;
        ALUCtrl  = w_alu_ctrl;
        MemRead  = w_is_lw;
        MemWrite = w_is_sw;
      end
      StWb: begin
        w_state_next = StIf;
        ALUSrc       = w_alu_src;
        ALUCtrl      = w_alu_ctrl;
        RegWrite     = w_is_r | w_is_i | w_is_lw;
        MemToReg     = w_is_lw;
        loadPC       = 1'b1;
        PCSrc        = r_br_taken;
      end
      default: w_state_next = StIf;
    endcase
  end

`ifdef MULTICYCLE_CTRL_RETIRE_CNT_EN
  logic [31:0] r_retired_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_retired_cnt <= 32'd0;
    end else if (r_state == StWb) begin
      r_retired_cnt <= r_retired_cnt + 32'd1;
    end
  end

  assign retired_cnt = r_retired_cnt;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: table vectors, reset-in-MEM sequence,
// random instructions against a lookup-table reference model.
module tb_multicycle_ctrl;

  localparam int unsigned MEM_LAT = 3;

  typedef struct packed {
    logic [31:0] instr;
    logic        zero;
    logic        alusrc;
    logic [3:0]  aluctrl;
    logic        rw;
    logic        m2r;
    logic        mr;
    logic        mw;
    logic        pcsrc;
  } vec_t;

  logic        clk;
  logic        rst;
  logic [31:0] instr;
  logic        Zero;
  logic        PCSrc, ALUSrc, RegWrite, MemToReg, loadPC, MemRead, MemWrite;
  logic [3:0]  ALUCtrl;
`ifdef MULTICYCLE_CTRL_RETIRE_CNT_EN
  logic [31:0] retired_cnt;
`endif

  multicycle_ctrl #(.MEM_LATENCY(MEM_LAT)) u_dut (
    .clk      (clk),
    .rst      (rst),
    .instr    (instr),
    .Zero     (Zero),
    .PCSrc    (PCSrc),
    .ALUSrc   (ALUSrc),
    .RegWrite (RegWrite),
    .MemToReg (MemToReg),
    .ALUCtrl  (ALUCtrl),
    .loadPC   (loadPC),
    .MemRead  (MemRead),
    .MemWrite (MemWrite)
`ifdef MULTICYCLE_CTRL_RETIRE_CNT_EN
    ,
    .retired_cnt (retired_cnt)
`endif
  );

  logic [10:0] w_out;
  assign w_out = {PCSrc, ALUSrc, RegWrite, MemToReg, ALUCtrl, loadPC, MemRead, MemWrite};

  int n_vec = 0;
  int n_bad = 0;
  int n_retired = 0;
  vec_t tbl[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h", name, got, exp);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] ins, input logic z, input logic src,
                              input logic [3:0] ctl, input logic rw, input logic m2r,
                              input logic mr, input logic mw, input logic pc);
    vec_t v;
    v = '{instr: ins, zero: z, alusrc: src, aluctrl: ctl, rw: rw, m2r: m2r,
          mr: mr, mw: mw, pcsrc: pc};
    return v;
  endfunction

  // Reference model: opcode class plus a funct3-indexed op table.
  function automatic vec_t model(input logic [31:0] ins, input logic z);
    logic [3:0] op_tbl [8];
    logic [2:0] f3;
    vec_t v;
    op_tbl = '{4'b0010, 4'b1001, 4'b0111, 4'b0010, 4'b0101, 4'b1000, 4'b0001, 4'b0000};
    f3 = ins[14:12];
    v = mk(ins, z, 1'b0, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    case (ins[6:0])
      7'b0110011: begin
        v.rw = 1'b1;
        v.aluctrl = op_tbl[f3];
        if (ins[30] && f3 == 3'd0) v.aluctrl = 4'b0110;
        if (ins[30] && f3 == 3'd5) v.aluctrl = 4'b1010;
      end
      7'b0010011: begin
        v.rw = 1'b1;
        v.alusrc = 1'b1;
        v.aluctrl = op_tbl[f3];
        if (ins[30] && f3 == 3'd5) v.aluctrl = 4'b1010;
      end
      7'b0000011: begin v.alusrc = 1'b1; v.rw = 1'b1; v.m2r = 1'b1; v.mr = 1'b1; end
      7'b0100011: begin v.alusrc = 1'b1; v.mw = 1'b1; end
      7'b1100011: begin v.aluctrl = 4'b0110; v.pcsrc = z; end
      default: ;
    endcase
    return v;
  endfunction

  // phase: 0 IF, 1 ID, 2 EX, 3 MEM, 4 WB
  function automatic logic [10:0] exp_out(input vec_t v, input int ph);
    case (ph)
      0: return 11'd0;
      1, 2: return {1'b0, v.alusrc, 2'b00, v.aluctrl, 3'b000};
      3: return {1'b0, v.alusrc, 2'b00, v.aluctrl, 1'b0, v.mr, v.mw};
      default: return {v.pcsrc, v.alusrc, v.rw, v.m2r, v.aluctrl, 3'b100};
    endcase
  endfunction

  function automatic int phase_of(input int k);
    if (k < 3) return k;
    if (k == 3 + int'(MEM_LAT)) return 4;
    return 3;
  endfunction

  // Called one step after the edge that enters IF; returns at the same point of the next IF.
  task automatic run_instr(input vec_t v, input string tag);
    int ph;
    instr = v.instr;
    for (int k = 0; k < 4 + int'(MEM_LAT); k++) begin
      ph = phase_of(k);
      Zero = (ph == 2) ? v.zero : 1'($urandom);
      @(negedge clk);
      check($sformatf("%s %08h cyc%0d", tag, v.instr, k), 32'(w_out), 32'(exp_out(v, ph)));
      @(posedge clk);
      #1;
    end
    n_retired++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    n_retired = 0;
  endtask

  initial begin
    vec_t lw_v;
    vec_t v;
    logic [31:0] r;
    logic [6:0] ops [5];
    ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011};

    tbl.push_back(mk(32'h002081B3, 1'b0, 1'b0, 4'b0010, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(32'h00208463, 1'b1, 1'b0, 4'b0110, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
    tbl.push_back(mk(32'h00208463, 1'b0, 1'b0, 4'b0110, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(32'h0040A283, 1'b0, 1'b1, 4'b0010, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0));
    tbl.push_back(mk(32'h0050A423, 1'b1, 1'b1, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0));
    tbl.push_back(mk(32'h4021D213, 1'b0, 1'b1, 4'b1010, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(32'h0000007F, 1'b1, 1'b0, 4'b0010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(32'h402081B3, 1'b0, 1'b0, 4'b0110, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(32'h0020F1B3, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(32'h0040C193, 1'b0, 1'b1, 4'b0101, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(32'h0020A1B3, 1'b0, 1'b0, 4'b0111, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(32'h0020D1B3, 1'b0, 1'b0, 4'b1000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(32'h002091B3, 1'b0, 1'b0, 4'b1001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(32'h0020E1B3, 1'b0, 1'b0, 4'b0001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
    tbl.push_back(mk(32'h0020B1B3, 1'b0, 1'b0, 4'b0010, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));

    instr = 32'd0;
    Zero  = 1'b0;
    rst   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("reset outputs", 32'(w_out), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    foreach (tbl[i]) run_instr(tbl[i], "table");

    // Reset asserted in the 2nd MEM cycle of a load.
    lw_v = tbl[3];
    instr = lw_v.instr;
    for (int k = 0; k < 5; k++) begin
      Zero = 1'($urandom);
      if (k == 4) rst = 1'b1;
      @(negedge clk);
      check($sformatf("rst-seq cyc%0d", k), 32'(w_out), 32'(exp_out(lw_v, phase_of(k))));
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    n_retired = 0;
    // First instruction after reset must start cleanly in IF (all zero).
    run_instr(tbl[0], "post-rst");
    run_instr(tbl[1], "post-rst");

    for (int n = 0; n < 60; n++) begin
      r = $urandom;
      if (n % 6 != 5) begin
        r[6:0] = ops[n % 5];
      end else begin
        while (r[6:0] inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011})
          r = $urandom;
      end
      v = model(r, 1'($urandom));
      run_instr(v, "rand");
    end

`ifdef MULTICYCLE_CTRL_RETIRE_CNT_EN
    check("retired after run", retired_cnt, 32'(n_retired));
    do_reset();
    check("retired after reset", retired_cnt, 32'd0);
    run_instr(tbl[0], "cnt");
    run_instr(tbl[3], "cnt");
    run_instr(tbl[4], "cnt");
    run_instr(tbl[6], "cnt");
    check("retired 3+invalid", retired_cnt, 32'(n_retired));
`else
    do_reset();
    run_instr(tbl[6], "nop-after-reset");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
